// File: rtl/pc_seq_stack_pkg.sv
// Shared types and helpers for the program-counter sequencer.
//   pc_op_t  : operation code presented by decode/branch resolution.
//   depth_w  : width needed to count 0..entries return-stack entries.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_NEXT   = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4
  } pc_op_t;

  function automatic int unsigned depth_w(input int unsigned entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/pc_seq_stack_if.sv
// Control/status bundle between decode logic and the PC sequencer.
//   master : decode side, drives en/op/dir/offset/target/halt_req, reads status.
//   slave  : sequencer side, drives PC/halt/depth/stack_err.
interface pc_seq_stack_if #(
  parameter int unsigned PC_W        = 10,
  parameter int unsigned OFF_W       = 8,
  parameter int unsigned STACK_DEPTH = 4
);
  import pc_pkg::*;

  localparam int unsigned DEPTH_W = depth_w(STACK_DEPTH);

  logic               en;
  pc_op_t             op;
  logic               dir;
  logic [OFF_W-1:0]   offset;
  logic [PC_W-1:0]    target;
  logic               halt_req;
  logic [PC_W-1:0]    PC;
  logic               halt;
  logic [DEPTH_W-1:0] depth;
  logic               stack_err;

  modport master (
    output en, op, dir, offset, target, halt_req,
    input  PC, halt, depth, stack_err
  );

  modport slave (
    input  en, op, dir, offset, target, halt_req,
    output PC, halt, depth, stack_err
  );

endinterface

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack.
//   CLK, init_n : clock, asynchronous active-low reset (clears the pointer only)
//   push, pop   : push din / discard top; push ignored when full, pop when empty
//   din         : address to push
//   dout        : current top entry (don't-care when empty)
//   depth       : number of valid entries
//   full, empty : status
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned DW   = depth_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             init_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    ptr_q, ptr_d;
  logic [DW-1:0]    top_ptr;
  logic             do_push, do_pop;

  assign full    = (ptr_q == DW'(DEPTH));
  assign empty   = (ptr_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !do_push;
  assign top_ptr = ptr_q - 1'b1;
  assign dout    = mem_q[top_ptr[AW-1:0]];
  assign depth   = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (do_push) begin
      ptr_d = ptr_q + 1'b1;
    end else if (do_pop) begin
      ptr_d = ptr_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Contents need no reset: only entries below the pointer are ever read.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_seq_stack.sv
// Parametrised program-counter sequencer with return stack and sticky halt.
//   CLK    : clock, rising edge
//   init_n : asynchronous active-low reset
//   bus    : slave side of pc_seq_stack_if
//            in : en (0 = stall), op, dir (1 = add), offset, target, halt_req
//            out: PC (instruction address), halt, depth, stack_err (all registered)
module pc_seq_stack
  import pc_pkg::*;
#(
  parameter int unsigned PC_W         = 10,
  parameter int unsigned OFF_W        = 8,
  parameter int unsigned STACK_DEPTH  = 4,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned HALT_ADDR    = 7,
  parameter bit          HALT_ADDR_EN = 1'b1
) (
  input logic           CLK,
  input logic           init_n,
  pc_seq_stack_if.slave bus
);

  localparam int unsigned DEPTH_W = depth_w(STACK_DEPTH);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic               halt_q, halt_d;
  logic               err_q, err_d;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    off_ext;
  logic               push, pop;
  logic [PC_W-1:0]    stk_top;
  logic [DEPTH_W-1:0] stk_depth;
  logic               stk_full, stk_empty;

  assign pc_inc  = pc_q + 1'b1;
  assign off_ext = PC_W'(bus.offset);

  pc_ret_stack #(
    .WIDTH (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .CLK    (CLK),
    .init_n (init_n),
    .push   (push),
    .pop    (pop),
    .din    (pc_inc),
    .dout   (stk_top),
    .depth  (stk_depth),
    .full   (stk_full),
    .empty  (stk_empty)
  );

  always_comb begin
    pc_d   = pc_q;
    halt_d = halt_q;
    err_d  = err_q;
    push   = 1'b0;
    pop    = 1'b0;
    // Once halted everything is frozen until reset.
    if (!halt_q) begin
      if (bus.halt_req) begin
        halt_d = 1'b1;
      end else if (HALT_ADDR_EN && bus.en && (pc_q == PC_W'(HALT_ADDR))) begin
        halt_d = 1'b1;
      end else if (bus.en) begin
        case (bus.op)
          PC_BRANCH: pc_d = bus.dir ? (pc_q + off_ext) : (pc_q - off_ext);
          PC_JUMP:   pc_d = bus.target;
          PC_CALL: begin
            if (!stk_full) begin
              push = 1'b1;
              pc_d = bus.target;
            end else begin
              pc_d  = pc_inc;
              err_d = 1'b1;
            end
          end
          PC_RET: begin
            if (!stk_empty) begin
              pop  = 1'b1;
              pc_d = stk_top;
            end else begin
              pc_d  = pc_inc;
              err_d = 1'b1;
            end
          end
          // NEXT and unassigned codes 5-7 all advance by one.
          default:   pc_d = pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      pc_q   <= PC_W'(RESET_PC);
      halt_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
      err_q  <= err_d;
    end
  end

  assign bus.PC        = pc_q;
  assign bus.halt      = halt_q;
  assign bus.depth     = stk_depth;
  assign bus.stack_err = err_q;

endmodule

// File: tb/tb_pc_seq_stack.sv
// Directed bench for pc_seq_stack with default parameters
// (PC_W=10, OFF_W=8, STACK_DEPTH=4, RESET_PC=0, HALT_ADDR=7, HALT_ADDR_EN=1).
module tb_pc_seq_stack;
  import pc_pkg::*;

  logic CLK;
  logic init_n;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pc_seq_stack_if #(.PC_W(10), .OFF_W(8), .STACK_DEPTH(4)) bus ();

  pc_seq_stack #(
    .PC_W         (10),
    .OFF_W        (8),
    .STACK_DEPTH  (4),
    .RESET_PC     (0),
    .HALT_ADDR    (7),
    .HALT_ADDR_EN (1'b1)
  ) dut (
    .CLK    (CLK),
    .init_n (init_n),
    .bus    (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one op, let one edge pass, then sample 1 time unit later.
  task automatic step(input logic e, input logic [2:0] o, input logic d,
                      input logic [7:0] off, input logic [9:0] tgt, input logic hr);
    bus.en       = e;
    bus.op       = pc_op_t'(o);
    bus.dir      = d;
    bus.offset   = off;
    bus.target   = tgt;
    bus.halt_req = hr;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_st(input string tag, input int unsigned pc, input int unsigned dep,
                        input int unsigned hlt, input int unsigned err);
    chk({tag, ".pc"}, 32'(bus.PC), pc);
    chk({tag, ".depth"}, 32'(bus.depth), dep);
    chk({tag, ".halt"}, 32'(bus.halt), hlt);
    chk({tag, ".err"}, 32'(bus.stack_err), err);
  endtask

  initial begin
    init_n       = 1'b0;
    bus.en       = 1'b0;
    bus.op       = PC_NEXT;
    bus.dir      = 1'b0;
    bus.offset   = '0;
    bus.target   = '0;
    bus.halt_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_st("reset", 0, 0, 0, 0);
    init_n = 1'b1;

    // Sequential advance, then stall
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 3'd0, 1'b0, 8'd0, 10'd0, 1'b0);
      chk($sformatf("next%0d", i), 32'(bus.PC), i);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd2, 1'b0, 8'd0, 10'd99, 1'b0);
      chk($sformatf("stall%0d", i), 32'(bus.PC), 5);
    end
    step(1'b1, 3'd6, 1'b0, 8'd0, 10'd0, 1'b0);
    chk("op6_next", 32'(bus.PC), 6);

    // Branches with wrap and self-loop
    step(1'b1, 3'd2, 1'b0, 8'd0, 10'd3, 1'b0);
    chk("jump3", 32'(bus.PC), 3);
    step(1'b1, 3'd1, 1'b1, 8'd200, 10'd0, 1'b0);
    chk("br_fwd", 32'(bus.PC), 203);
    step(1'b1, 3'd1, 1'b0, 8'd210, 10'd0, 1'b0);
    chk("br_back_wrap", 32'(bus.PC), 1017);
    step(1'b1, 3'd1, 1'b1, 8'd0, 10'd0, 1'b0);
    chk("br_zero", 32'(bus.PC), 1017);
    step(1'b1, 3'd1, 1'b1, 8'd10, 10'd0, 1'b0);
    chk("br_fwd_wrap", 32'(bus.PC), 3);

    // Call/return nesting and underflow
    step(1'b1, 3'd2, 1'b0, 8'd0, 10'd10, 1'b0);
    chk("jump10", 32'(bus.PC), 10);
    step(1'b1, 3'd3, 1'b0, 8'd0, 10'd100, 1'b0);
    chk_st("call100", 100, 1, 0, 0);
    step(1'b1, 3'd3, 1'b0, 8'd0, 10'd200, 1'b0);
    chk_st("call200", 200, 2, 0, 0);
    step(1'b1, 3'd4, 1'b0, 8'd0, 10'd0, 1'b0);
    chk_st("ret1", 101, 1, 0, 0);
    step(1'b1, 3'd4, 1'b0, 8'd0, 10'd0, 1'b0);
    chk_st("ret2", 11, 0, 0, 0);
    step(1'b1, 3'd4, 1'b0, 8'd0, 10'd0, 1'b0);
    chk_st("ret_underflow", 12, 0, 0, 1);

    // Clear the sticky error, then fill and overflow the stack
    init_n = 1'b0;
    #2;
    chk_st("reset2", 0, 0, 0, 0);
    init_n = 1'b1;
    step(1'b1, 3'd3, 1'b0, 8'd0, 10'd20, 1'b0);
    chk_st("fill1", 20, 1, 0, 0);
    step(1'b1, 3'd3, 1'b0, 8'd0, 10'd30, 1'b0);
    chk_st("fill2", 30, 2, 0, 0);
    step(1'b1, 3'd3, 1'b0, 8'd0, 10'd40, 1'b0);
    chk_st("fill3", 40, 3, 0, 0);
    step(1'b1, 3'd3, 1'b0, 8'd0, 10'd60, 1'b0);
    chk_st("fill4", 60, 4, 0, 0);
    step(1'b1, 3'd3, 1'b0, 8'd0, 10'd50, 1'b0);
    chk_st("call_overflow", 61, 4, 0, 1);
    step(1'b1, 3'd4, 1'b0, 8'd0, 10'd0, 1'b0);
    chk_st("ret_top", 41, 3, 0, 1);
    step(1'b1, 3'd4, 1'b0, 8'd0, 10'd0, 1'b0);
    chk_st("ret_next", 31, 2, 0, 1);

    // Return address wraps from 1023 to 0
    step(1'b1, 3'd2, 1'b0, 8'd0, 10'd1023, 1'b0);
    chk("jump1023", 32'(bus.PC), 1023);
    step(1'b1, 3'd3, 1'b0, 8'd0, 10'd300, 1'b0);
    chk_st("call_wrap", 300, 3, 0, 1);
    step(1'b1, 3'd4, 1'b0, 8'd0, 10'd0, 1'b0);
    chk_st("ret_wrap", 0, 2, 0, 1);

    // Address-triggered halt and freeze
    step(1'b1, 3'd2, 1'b0, 8'd0, 10'd5, 1'b0);
    chk("jump5", 32'(bus.PC), 5);
    step(1'b1, 3'd0, 1'b0, 8'd0, 10'd0, 1'b0);
    chk_st("to6", 6, 2, 0, 1);
    step(1'b1, 3'd0, 1'b0, 8'd0, 10'd0, 1'b0);
    chk_st("to7", 7, 2, 0, 1);
    step(1'b1, 3'd0, 1'b0, 8'd0, 10'd0, 1'b0);
    chk_st("addr_halt", 7, 2, 1, 1);
    step(1'b1, 3'd2, 1'b0, 8'd0, 10'd0, 1'b0);
    chk_st("halt_jump", 7, 2, 1, 1);
    step(1'b1, 3'd4, 1'b0, 8'd0, 10'd0, 1'b0);
    chk_st("halt_ret", 7, 2, 1, 1);
    #2;
    init_n = 1'b0;
    #1;
    chk_st("async_reset", 0, 0, 0, 0);
    #1;
    init_n = 1'b1;

    // External halt with stall and a simultaneous CALL
    step(1'b1, 3'd2, 1'b0, 8'd0, 10'd42, 1'b0);
    chk("jump42", 32'(bus.PC), 42);
    step(1'b0, 3'd3, 1'b0, 8'd0, 10'd100, 1'b1);
    chk_st("halt_req", 42, 0, 1, 0);
    step(1'b1, 3'd3, 1'b0, 8'd0, 10'd100, 1'b0);
    chk_st("halt_req_frozen", 42, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq_stack.md
Name: pc_seq_stack

Overview:
- Parametrised program-counter sequencer; successor to the fixed 10-bit branch/halt PC.
- Adds several features over the fixed PC:
  - generic PC and offset widths
  - absolute jump
  - call/return through a hardware return stack
  - stall
  - external and address-triggered sticky halt
- Sits between the decode/branch-resolution logic and instruction memory. Its PC output drives the instruction-memory address directly.

Parameters:
- PC_W, 10: PC width in bits; all PC arithmetic is modulo 2^PC_W.
- OFF_W, 8: branch offset magnitude width; OFF_W <= PC_W.
- STACK_DEPTH, 4: return-stack entries; must be >= 1.
- RESET_PC, 0: PC value loaded on reset.
- HALT_ADDR, 7: address that triggers halt.
- HALT_ADDR_EN, 1: 1 enables address-triggered halt; 0 disables it.

Ports:
- CLK  in  1  Clock; all state changes on the rising edge.
- init_n  in  1  Reset, asynchronous, active-low.
- en  in  1  Advance enable; 0 = stall.
- op  in  3  Operation code (pc_op_t).
- dir  in  1  Branch direction: 1 = forward (add), 0 = backward (subtract).
- offset  in  OFF_W  Branch magnitude, unsigned, zero-extended to PC_W.
- target  in  PC_W  Absolute destination for JUMP and CALL.
- halt_req  in  1  External halt request.
- PC  out  PC_W  Current program counter, registered.
- halt  out  1  Sticky halted flag, registered.
- depth  out  $clog2(STACK_DEPTH+1)  Number of valid return-stack entries.
- stack_err  out  1  Sticky flag: a CALL overflowed or a RET underflowed.

Behaviour:
- Reset (init_n=0, asynchronous, takes effect immediately): PC=RESET_PC, halt=0, depth=0, stack_err=0. Stack contents are don't-care. Reset mid-operation discards any pending op.
- All outputs are registered. An op presented in cycle N is visible on PC after the edge that ends cycle N (1-cycle latency).
- Freeze condition: when halt=1, PC, depth and stack_err are frozen until reset, regardless of en, op or halt_req.
- halt_req=1 at an edge (any en): halt<=1, PC holds, op is ignored, stack is untouched.
- Address halt: HALT_ADDR_EN=1, en=1, PC==HALT_ADDR at an edge gives halt<=1, PC holds at HALT_ADDR, op is ignored.
- Stall: en=0 (no halt_req) leaves all state unchanged.
- Ops when en=1 and neither halt condition fires:
  - NEXT (0): PC<=PC+1.
  - BRANCH (1): PC<=PC+offset if dir=1, else PC-offset. Wraps modulo 2^PC_W in both directions.
  - JUMP (2): PC<=target.
  - CALL (3): if depth<STACK_DEPTH, push PC+1 (wrapped), depth+1, PC<=target. If full: no push, PC<=PC+1, stack_err<=1.
  - RET (4): if depth>0, PC<=top entry, depth-1. If empty: PC<=PC+1, stack_err<=1.
  - Codes 5-7: treated as NEXT.
- Priority: init_n > halt (frozen) > halt_req > address halt > en > op.
- BRANCH with offset=0 leaves PC unchanged (a legal self-loop).
- A CALL whose return address wraps from 2^PC_W-1 pushes 0.
- Stack is LIFO. At most one push or pop occurs per cycle.
- stack_err has no effect on sequencing other than the fallback PC+1.
- No simulation $display in RTL; tracing is done by the bench.

Decomposition:
- Package pc_pkg holds:
  - typedef enum logic [2:0] pc_op_t {PC_NEXT, PC_BRANCH, PC_JUMP, PC_CALL, PC_RET}
  - the shared depth-width function
- One sub-module, pc_ret_stack, parameterised by WIDTH and DEPTH.
  - Ports: CLK, init_n, push, pop, din, dout(top), depth, full, empty.
  - Register array plus pointer.
  - Ignores push when full and pop when empty. Overflow/underflow flagging stays in the parent.

Test Plan:
- Reset to RESET_PC=0, then 5 cycles of NEXT with en=1 and HALT_ADDR_EN=0 -> PC 1,2,3,4,5. Drop en for 3 cycles -> PC stays 5.
- PC=3, BRANCH dir=1 offset=200 -> PC=203. Then BRANCH dir=0 offset=210 -> PC=1017 (wrap, PC_W=10). Then BRANCH offset=0 -> PC=1017.
- PC=10, CALL target=100 -> PC=100, depth=1. CALL target=200 -> PC=200, depth=2. RET -> PC=101, depth=1. RET -> PC=11, depth=0. RET -> PC=12, stack_err=1.
- Fill the stack with 4 CALLs, then a 5th CALL target=50 from PC=P -> PC=P+1, depth=4, stack_err=1. Next RET returns the 4th pushed address.
- HALT_ADDR_EN=1, HALT_ADDR=7, NEXT from 5 -> PC 6, 7, then halt=1 with PC=7 held. Subsequent JUMP target=0 is ignored. Assert init_n low mid-cycle -> PC=0 and halt=0 immediately.
- halt_req=1 with en=0 at PC=42 -> halt=1, PC=42. A simultaneous op=CALL is not pushed (depth unchanged).
